// File: rtl/dm_lsu.sv
// Load/store unit between the MEM stage and the word-only dm memory: range/alignment
// checking, big-endian lane extraction on loads, read-modify-write on sub-word stores.
module dm_lsu #(
  parameter int NBIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_r,
  output logic        dm_w,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [2:0]  dm_op,
  input  logic [31:0] dm_rdata
);

  localparam logic [2:0] DM_OP_WD = 3'd0;
  localparam logic [2:0] DM_OP_BS = 3'd1;
  localparam logic [2:0] DM_OP_BZ = 3'd2;
  localparam logic [2:0] DM_OP_HS = 3'd3;
  localparam logic [2:0] DM_OP_HZ = 3'd4;
  localparam logic [2:0] DM_OP_SB = 3'd5;
  localparam logic [2:0] DM_OP_SH = 3'd6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_RESP = 2'd3} state_t;

  function automatic logic req_error(input logic we, input logic [2:0] op, input logic [31:0] addr);
    logic ill, mis, oor;
    ill = 1'b0;
    mis = 1'b0;
    case (op)
      DM_OP_WD: mis = (addr[1:0] != 2'b00);
      DM_OP_BS, DM_OP_BZ: ill = we;
      DM_OP_HS, DM_OP_HZ: begin
        ill = we;
        mis = addr[0];
      end
      DM_OP_SB: ill = !we;
      DM_OP_SH: begin
        ill = !we;
        mis = addr[0];
      end
      default: ill = 1'b1;
    endcase
    oor = ((addr >> (NBIT + 2)) != 32'd0);
    return ill | mis | oor;
  endfunction

  // Byte offset k lives in bits [31-8k -: 8]; half offset 0 is the upper half.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (op)
      DM_OP_BS: r = {{24{b[7]}}, b};
      DM_OP_BZ: r = {24'd0, b};
      DM_OP_HS: r = {{16{h[15]}}, h};
      DM_OP_HZ: r = {16'd0, h};
      default:  r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (op == DM_OP_SH) begin
      if (off[1]) r[15:0] = wd[15:0];
      else        r[31:16] = wd[15:0];
    end else begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        dm_r_q, dm_r_d;
  logic        dm_w_q, dm_w_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    dm_r_d       = 1'b0;
    dm_w_d       = 1'b0;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          op_d        = req_op;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          dm_addr_d   = {req_addr[31:2], 2'b00};
          req_ready_d = 1'b0;
          if (req_error(req_we, req_op, req_addr)) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (req_we && (req_op == DM_OP_WD)) begin
            state_d    = S_WR;
            dm_w_d     = 1'b1;
            dm_wdata_d = req_wdata;
          end else begin
            state_d = S_RD;
            dm_r_d  = 1'b1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d    = S_WR;
          dm_w_d     = 1'b1;
          dm_wdata_d = store_merge(op_q, off_q, dm_rdata, wdata_q);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_extract(op_q, off_q, dm_rdata);
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'd0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      op_q         <= 3'd0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      dm_r_q       <= 1'b0;
      dm_w_q       <= 1'b0;
      dm_addr_q    <= 32'd0;
      dm_wdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      dm_r_q       <= dm_r_d;
      dm_w_q       <= dm_w_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  // rst_n gates the write strobe so a reset landing in WR never commits.
  assign req_ready  = req_ready_q & rst_n;
  assign dm_w       = dm_w_q & rst_n;
  assign dm_r       = dm_r_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_op      = DM_OP_WD;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
